// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: the repeat FSM state encoding
// and the helper that sizes the filter and repeat counters.
package debounce_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: input synchronizer, stability filter, edge pulses
// and the optional auto-repeat FSM that runs while the debounced level is high.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam bit            RPT_EN  = (REPEAT_DELAY > 0);
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = cnt_width(RMAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   cand_q, cand_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    rpt_state_e             state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   rpt_q, rpt_d;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // dout follows the candidate once the counter has saturated, i.e. after
    // STABLE_CYCLES identical samples, even if the newest sample disagrees.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == CNT_MAX) begin
            dout_d = cand_q;
        end
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    // Repeat FSM looks at the next dout so a release never coincides with rpt.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        unique case (state_q)
            RPT_IDLE: begin
                if (RPT_EN && rise_d) begin
                    state_d = RPT_DELAY;
                    rcnt_d  = '0;
                end
            end
            RPT_DELAY: begin
                if (!dout_d) begin
                    state_d = RPT_IDLE;
                end else if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                    rpt_d   = 1'b1;
                    state_d = RPT_REPEAT;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            RPT_REPEAT: begin
                if (!dout_d) begin
                    state_d = RPT_IDLE;
                end else if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                    rpt_d  = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
            rpt_q   <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rpt_q   <= rpt_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign rpt  = rpt_q & RPT_EN;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer; each bit of din is handled by its own
// independent debounce_chan instance.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int STABLE_CYCLES = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rpt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .din (din[i]),
            .dout(dout[i]),
            .rise(rise[i]),
            .fall(fall[i]),
            .rpt (rpt[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed latency, glitch, repeat,
// multi-channel and reset scenarios, then random stimulus against a window model.
module tb_button_debouncer;

    localparam int N_CH          = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int REPEAT_DELAY  = 10;
    localparam int REPEAT_PERIOD = 5;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] din = '0;
    logic [N_CH-1:0] dout, rise, fall, rpt;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [N_CH-1:0] xHist[$];
    logic [N_CH-1:0] expDout = '0;
    logic [N_CH-1:0] expRise = '0;
    logic [N_CH-1:0] expFall = '0;
    logic [N_CH-1:0] expRpt  = '0;
    int              age[N_CH];

    button_debouncer #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .rpt (rpt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] d, input logic r);
        din = d;
        rst = r;
    endtask

    // Model: dout takes a level once the STABLE_CYCLES raw samples that sit
    // SYNC_STAGES+1 edges back all agree; rpt is derived from time since rise.
    task automatic modelEdge();
        logic [N_CH-1:0] newDout;
        bit              same;
        if (rst) begin
            xHist = {};
            repeat (SYNC_STAGES + STABLE_CYCLES) xHist.push_back('0);
            newDout = '0;
            expRise = '0;
            expFall = '0;
            expRpt  = '0;
            for (int c = 0; c < N_CH; c++) age[c] = -1;
        end else begin
            newDout = expDout;
            for (int c = 0; c < N_CH; c++) begin
                same = 1'b1;
                for (int k = 1; k < STABLE_CYCLES; k++)
                    if (xHist[k][c] !== xHist[0][c]) same = 1'b0;
                if (same) newDout[c] = xHist[0][c];
            end
            xHist.push_back(din);
            void'(xHist.pop_front());
            expRise = newDout & ~expDout;
            expFall = ~newDout & expDout;
            for (int c = 0; c < N_CH; c++) begin
                expRpt[c] = 1'b0;
                if (!newDout[c]) begin
                    age[c] = -1;
                end else if (expRise[c]) begin
                    age[c] = 0;
                end else begin
                    age[c]++;
                    expRpt[c] = (age[c] == REPEAT_DELAY) ||
                                (age[c] > REPEAT_DELAY &&
                                 (age[c] - REPEAT_DELAY) % REPEAT_PERIOD == 0);
                end
            end
        end
        expDout = newDout;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_dout", 32'(dout), 32'(expDout));
        checkOutput("model_rise", 32'(rise), 32'(expRise));
        checkOutput("model_fall", 32'(fall), 32'(expFall));
        checkOutput("model_rpt",  32'(rpt),  32'(expRpt));
    endtask

    initial begin
        // reset state
        applyStimulus('0, 1'b1);
        repeat (3) tick();
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_rise", 32'(rise), 32'd0);
        checkOutput("reset_rpt",  32'(rpt),  32'd0);
        applyStimulus('0, 1'b0);
        repeat (10) tick();

        // single press: latency, one-cycle rise, repeat cadence, release
        applyStimulus(2'b01, 1'b0);
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) checkOutput("press_early_dout", 32'(dout[0]), 32'd0);
        end
        checkOutput("press_dout", 32'(dout[0]), 32'd1);
        checkOutput("press_rise", 32'(rise[0]), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            checkOutput($sformatf("rpt_at_%0d", k), 32'(rpt[0]),
                        32'(k == 10 || k == 15 || k == 20 || k == 25));
            if (k == 1)  checkOutput("rise_one_cycle", 32'(rise[0]), 32'd0);
            if (k == 28) checkOutput("held_dout", 32'(dout[0]), 32'd1);
            if (k == 29) begin
                checkOutput("release_fall", 32'(fall[0]), 32'd1);
                checkOutput("release_dout", 32'(dout[0]), 32'd0);
            end
            if (k == 22) applyStimulus(2'b00, 1'b0);
        end

        // short glitch must be rejected
        applyStimulus(2'b01, 1'b0);
        repeat (3) tick();
        applyStimulus(2'b00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            checkOutput("glitch_dout", 32'(dout[0]), 32'd0);
            checkOutput("glitch_edges", 32'({rise[0], fall[0]}), 32'd0);
        end

        // both channels together
        applyStimulus(2'b11, 1'b0);
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) checkOutput("dual_early_rise", 32'(rise), 32'd0);
        end
        checkOutput("dual_rise", 32'(rise), 32'b11);
        checkOutput("dual_dout", 32'(dout), 32'b11);
        for (int k = 1; k <= REPEAT_DELAY; k++) tick();
        checkOutput("dual_rpt", 32'(rpt), 32'b11);
        applyStimulus(2'b00, 1'b0);
        repeat (12) tick();

        // reset in the middle of a count
        applyStimulus(2'b01, 1'b0);
        repeat (2) tick();
        applyStimulus(2'b01, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("midreset_outs", 32'({dout, rise, fall, rpt}), 32'd0);
        end
        applyStimulus(2'b01, 1'b0);
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) checkOutput("postreset_early_dout", 32'(dout[0]), 32'd0);
        end
        checkOutput("postreset_dout", 32'(dout[0]), 32'd1);
        checkOutput("postreset_rise", 32'(rise[0]), 32'd1);

        // random stimulus with mostly long holds and occasional glitches/resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0)
                applyStimulus(N_CH'($urandom), 1'b0);
            else
                applyStimulus(din, 1'b0);
            if ($urandom_range(0, 399) == 0) applyStimulus(din, 1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
